// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - parametrised coin vend controller with greedy change return
//
// Purpose: accumulates nickel/dime/quarter credit up to PRICE, requests one
// dispense by handshake, then returns any remaining credit one coin at a
// time (25/10/5, largest first). Cancel in COLLECT refunds all credit.
// Coins that cannot be accepted produce a one-cycle coin_rej pulse.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   n, d, q                coin inserted pulses (5c, 10c, 25c)
//   nm                     cancel / no-more-money pulse
//   dis_done               dispense mechanism finished
//   ret_ack                ejector returned the currently requested coin
//   dis                    dispense request, held until dis_done
//   rn, rd, rq             return nickel/dime/quarter request, held until ret_ack
//   coin_rej               coin rejected (registered pulse)
//   credit                 current credit in cents
//   busy                   high while vending or returning change
module vend_controller #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          n,
    input  logic          d,
    input  logic          q,
    input  logic          nm,
    input  logic          dis_done,
    input  logic          ret_ack,
    output logic          dis,
    output logic          rn,
    output logic          rd,
    output logic          rq,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [CW:0]   MAX_X   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0]   PRICE_X = (CW+1)'(PRICE);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] C25     = CW'(25);
    localparam logic [CW-1:0] C10     = CW'(10);
    localparam logic [CW-1:0] C5      = CW'(5);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          rej_d;
    logic          coin_rej_q, dis_q, rn_q, rd_q, rq_q, busy_q;

    logic          coin_any, coin_multi;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;
    logic [CW-1:0] chg_val;

    // Greedy coin choice for the change currently owed.
    function automatic logic [CW-1:0] change_coin(input logic [CW-1:0] c);
        if (c >= C25)      return C25;
        else if (c >= C10) return C10;
        else               return C5;
    endfunction

    always_comb begin
        coin_any   = n | d | q;
        coin_multi = (n & d) | (n & q) | (d & q);
        coin_val   = '0;
        if (q)      coin_val = (CW+1)'(25);
        else if (d) coin_val = (CW+1)'(10);
        else if (n) coin_val = (CW+1)'(5);
        // One extra bit so a coin landing near the top of the range cannot wrap.
        sum     = {1'b0, credit_q} + coin_val;
        chg_val = change_coin(credit_q);

        state_d  = state_q;
        credit_d = credit_q;
        rej_d    = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (nm) begin
                    // Cancel beats any coin in the same cycle.
                    rej_d = coin_any;
                    if (state_q == S_COLLECT) state_d = S_CHANGE;
                end else if (coin_multi) begin
                    rej_d = 1'b1;
                end else if (coin_any) begin
                    if (sum > MAX_X) begin
                        rej_d = 1'b1;
                    end else begin
                        credit_d = sum[CW-1:0];
                        state_d  = (sum >= PRICE_X) ? S_VEND : S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                rej_d = coin_any;
                if (dis_done) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
                end
            end
            S_CHANGE: begin
                rej_d = coin_any;
                if (ret_ack) begin
                    credit_d = credit_q - chg_val;
                    state_d  = (credit_q == chg_val) ? S_IDLE : S_CHANGE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state/credit so they equal a
    // decode of the registered state without any same-cycle input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
            dis_q      <= 1'b0;
            rn_q       <= 1'b0;
            rd_q       <= 1'b0;
            rq_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= rej_d;
            dis_q      <= (state_d == S_VEND);
            busy_q     <= (state_d == S_VEND) || (state_d == S_CHANGE);
            rq_q       <= (state_d == S_CHANGE) && (credit_d >= C25);
            rd_q       <= (state_d == S_CHANGE) && (credit_d < C25) && (credit_d >= C10);
            rn_q       <= (state_d == S_CHANGE) && (credit_d < C10) && (credit_d >= C5);
        end
    end

    assign dis      = dis_q;
    assign rn       = rn_q;
    assign rd       = rd_q;
    assign rq       = rq_q;
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller
module tb_vend_controller;

    logic       clk;
    logic       reset;
    logic       a_n, a_d, a_q, a_nm, a_dd, a_ra;
    logic       a_dis, a_rn, a_rd, a_rq, a_rej, a_busy;
    logic [7:0] a_credit;
    logic       b_n, b_d, b_q, b_nm, b_dd, b_ra;
    logic       b_dis, b_rn, b_rd, b_rq, b_rej, b_busy;
    logic [7:0] b_credit;

    int tests_run = 0;
    int tests_failed = 0;

    vend_controller #(.PRICE(25), .MAX_CREDIT(95), .CW(8)) u_a (
        .clk(clk), .reset(reset), .n(a_n), .d(a_d), .q(a_q), .nm(a_nm),
        .dis_done(a_dd), .ret_ack(a_ra), .dis(a_dis), .rn(a_rn), .rd(a_rd),
        .rq(a_rq), .coin_rej(a_rej), .credit(a_credit), .busy(a_busy)
    );

    vend_controller #(.PRICE(75), .MAX_CREDIT(80), .CW(8)) u_b (
        .clk(clk), .reset(reset), .n(b_n), .d(b_d), .q(b_q), .nm(b_nm),
        .dis_done(b_dd), .ret_ack(b_ra), .dis(b_dis), .rn(b_rn), .rd(b_rd),
        .rq(b_rq), .coin_rej(b_rej), .credit(b_credit), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the PRICE=25 / MAX_CREDIT=95 instance.
    // mode: 0 = taking coins, 1 = waiting for dispense, 2 = paying out change.
    int m_credit, m_mode, m_rej;

    function automatic int greedy(input int c);
        if (c >= 25) return 25;
        if (c >= 10) return 10;
        if (c >= 5)  return 5;
        return 0;
    endfunction

    task automatic model_step(input bit n, input bit d, input bit q, input bit nm,
                              input bit dd, input bit ra);
        int coins, val;
        coins = int'(n) + int'(d) + int'(q);
        val   = 25 * int'(q) + 10 * int'(d) + 5 * int'(n);
        m_rej = 0;
        if (m_mode == 0) begin
            if (nm) begin
                m_rej = (coins > 0);
                if (m_credit > 0) m_mode = 2;
            end else if (coins > 1) begin
                m_rej = 1;
            end else if (coins == 1) begin
                if (m_credit + val > 95) m_rej = 1;
                else begin
                    m_credit += val;
                    if (m_credit >= 25) m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            m_rej = (coins > 0);
            if (dd) begin
                m_credit -= 25;
                m_mode = (m_credit > 0) ? 2 : 0;
            end
        end else begin
            m_rej = (coins > 0);
            if (ra) begin
                m_credit -= greedy(m_credit);
                if (m_credit == 0) m_mode = 0;
            end
        end
    endtask

    task automatic clear_inputs();
        {a_n, a_d, a_q, a_nm, a_dd, a_ra} = '0;
        {b_n, b_d, b_q, b_nm, b_dd, b_ra} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs on instance A, then release them.
    task automatic pulse_a(input bit n, input bit d, input bit q, input bit nm,
                           input bit dd, input bit ra);
        {a_n, a_d, a_q, a_nm, a_dd, a_ra} = {n, d, q, nm, dd, ra};
        tick();
        {a_n, a_d, a_q, a_nm, a_dd, a_ra} = '0;
    endtask

    task automatic pulse_b(input bit n, input bit d, input bit q, input bit dd);
        {b_n, b_d, b_q, b_dd} = {n, d, q, dd};
        tick();
        {b_n, b_d, b_q, b_dd} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {a_n, a_d, a_q, a_nm, a_dd, a_ra} = 6'b001111;
        tick();
        tick();
        clear_inputs();
        reset = 1'b0;
        tests_run++;
        if ({a_credit, a_dis, a_rn, a_rd, a_rq, a_rej, a_busy} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_a: got credit=%0d dis=%b rn=%b rd=%b rq=%b rej=%b busy=%b, want all 0",
                     a_credit, a_dis, a_rn, a_rd, a_rq, a_rej, a_busy);
        end
        tests_run++;
        if ({b_credit, b_dis, b_rn, b_rd, b_rq, b_rej, b_busy} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_b: got credit=%0d dis=%b busy=%b, want all 0", b_credit, b_dis, b_busy);
        end
    endtask

    task automatic test_single_quarter();
        bit ret_seen;
        do_reset();
        pulse_a(0, 0, 1, 0, 0, 0);
        tests_run++;
        if (a_credit !== 8'd25 || a_dis !== 1'b1 || a_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_vend: credit=%0d dis=%b busy=%b, want 25 1 1", a_credit, a_dis, a_busy);
        end
        ret_seen = 0;
        repeat (3) begin
            tick();
            ret_seen |= a_rn | a_rd | a_rq;
        end
        tests_run++;
        if (a_dis !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_hold: dis=%b, want 1 until dis_done", a_dis);
        end
        pulse_a(0, 0, 0, 0, 1, 0);
        ret_seen |= a_rn | a_rd | a_rq;
        tick();
        ret_seen |= a_rn | a_rd | a_rq;
        tests_run++;
        if (a_credit !== 8'd0 || a_dis !== 1'b0 || a_busy !== 1'b0 || ret_seen) begin
            tests_failed++;
            $display("FAIL t1_done: credit=%0d dis=%b busy=%b ret_seen=%b, want 0 0 0 0",
                     a_credit, a_dis, a_busy, ret_seen);
        end
    endtask

    task automatic test_exact_change();
        do_reset();
        pulse_a(1, 0, 0, 0, 0, 0);
        pulse_a(0, 1, 0, 0, 0, 0);
        tests_run++;
        if (a_credit !== 8'd15 || a_dis !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_collect: credit=%0d dis=%b, want 15 0", a_credit, a_dis);
        end
        pulse_a(0, 0, 1, 0, 0, 0);
        tests_run++;
        if (a_credit !== 8'd40 || a_dis !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_vend: credit=%0d dis=%b, want 40 1", a_credit, a_dis);
        end
        pulse_a(0, 0, 0, 0, 1, 0);
        tick();
        tests_run++;
        if (a_credit !== 8'd15 || {a_dis, a_rq, a_rd, a_rn} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL t2_dime: credit=%0d dis/rq/rd/rn=%b, want 15 0010", a_credit, {a_dis, a_rq, a_rd, a_rn});
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        tests_run++;
        if (a_credit !== 8'd5 || {a_rq, a_rd, a_rn} !== 3'b001) begin
            tests_failed++;
            $display("FAIL t2_nickel: credit=%0d rq/rd/rn=%b, want 5 001", a_credit, {a_rq, a_rd, a_rn});
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        tests_run++;
        if (a_credit !== 8'd0 || {a_rq, a_rd, a_rn, a_busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t2_idle: credit=%0d rq/rd/rn/busy=%b, want 0 0000", a_credit, {a_rq, a_rd, a_rn, a_busy});
        end
    endtask

    task automatic test_cancel();
        bit dis_seen;
        dis_seen = 0;
        do_reset();
        pulse_a(0, 1, 0, 0, 0, 0);
        dis_seen |= a_dis;
        pulse_a(1, 0, 0, 0, 0, 0);
        dis_seen |= a_dis;
        pulse_a(0, 0, 0, 1, 0, 0);
        dis_seen |= a_dis;
        tick();
        dis_seen |= a_dis;
        tests_run++;
        if (a_credit !== 8'd15 || {a_rq, a_rd, a_rn, a_busy} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL t3_refund_dime: credit=%0d rq/rd/rn/busy=%b, want 15 0101", a_credit, {a_rq, a_rd, a_rn, a_busy});
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        dis_seen |= a_dis;
        tests_run++;
        if (a_credit !== 8'd5 || {a_rq, a_rd, a_rn} !== 3'b001) begin
            tests_failed++;
            $display("FAIL t3_refund_nickel: credit=%0d rq/rd/rn=%b, want 5 001", a_credit, {a_rq, a_rd, a_rn});
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        dis_seen |= a_dis;
        tests_run++;
        if (a_credit !== 8'd0 || a_busy !== 1'b0 || dis_seen) begin
            tests_failed++;
            $display("FAIL t3_idle: credit=%0d busy=%b dis_seen=%b, want 0 0 0", a_credit, a_busy, dis_seen);
        end
    endtask

    task automatic test_max_credit();
        do_reset();
        pulse_b(0, 0, 1, 0);
        pulse_b(0, 0, 1, 0);
        pulse_b(0, 1, 0, 0);
        pulse_b(0, 1, 0, 0);
        tests_run++;
        if (b_credit !== 8'd70 || b_dis !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_accum: credit=%0d dis=%b, want 70 0", b_credit, b_dis);
        end
        pulse_b(0, 0, 1, 0);
        tests_run++;
        if (b_rej !== 1'b1 || b_credit !== 8'd70 || b_dis !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_overmax: rej=%b credit=%0d dis=%b, want 1 70 0", b_rej, b_credit, b_dis);
        end
        pulse_b(1, 0, 0, 0);
        tests_run++;
        if (b_rej !== 1'b0 || b_credit !== 8'd75 || b_dis !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_price: rej=%b credit=%0d dis=%b, want 0 75 1", b_rej, b_credit, b_dis);
        end
        pulse_b(0, 0, 0, 1);
        tests_run++;
        if (b_credit !== 8'd0 || b_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_done: credit=%0d busy=%b, want 0 0", b_credit, b_busy);
        end
    endtask

    task automatic test_rejects();
        do_reset();
        pulse_a(1, 1, 0, 0, 0, 0);
        tests_run++;
        if (a_rej !== 1'b1 || a_credit !== 8'd0) begin
            tests_failed++;
            $display("FAIL t5_multi: rej=%b credit=%0d, want 1 0", a_rej, a_credit);
        end
        tick();
        tests_run++;
        if (a_rej !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_pulse_width: rej=%b, want 0", a_rej);
        end
        pulse_a(1, 0, 0, 0, 0, 0);
        pulse_a(0, 0, 1, 1, 0, 0);
        tests_run++;
        if (a_rej !== 1'b1 || a_credit !== 8'd5 || a_rn !== 1'b1 || a_dis !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_cancel_coin: rej=%b credit=%0d rn=%b dis=%b, want 1 5 1 0", a_rej, a_credit, a_rn, a_dis);
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        pulse_a(0, 0, 1, 0, 0, 0);
        pulse_a(1, 0, 0, 1, 0, 0);
        tests_run++;
        if (a_rej !== 1'b1 || a_credit !== 8'd25 || a_dis !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_vend_coin: rej=%b credit=%0d dis=%b, want 1 25 1", a_rej, a_credit, a_dis);
        end
        pulse_a(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        pulse_a(0, 1, 0, 0, 0, 0);
        pulse_a(1, 0, 0, 0, 0, 0);
        pulse_a(0, 0, 0, 1, 0, 0);
        tests_run++;
        if (a_rd !== 1'b1 || a_credit !== 8'd15) begin
            tests_failed++;
            $display("FAIL t6_setup: rd=%b credit=%0d, want 1 15", a_rd, a_credit);
        end
        do_reset();
        tests_run++;
        if (a_credit !== 8'd0 || {a_rq, a_rd, a_rn, a_busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t6_reset: credit=%0d rq/rd/rn/busy=%b, want 0 0000", a_credit, {a_rq, a_rd, a_rn, a_busy});
        end
        pulse_a(0, 0, 0, 0, 0, 1);
        tests_run++;
        if (a_credit !== 8'd0 || {a_rq, a_rd, a_rn, a_busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t6_ack_ignored: credit=%0d rq/rd/rn/busy=%b, want 0 0000", a_credit, {a_rq, a_rd, a_rn, a_busy});
        end
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        int r;
        bit rst;
        do_reset();
        m_credit = 0;
        m_mode   = 0;
        m_rej    = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            {a_n, a_d, a_q} = 3'b000;
            if (r < 15)      a_n = 1'b1;
            else if (r < 30) a_d = 1'b1;
            else if (r < 45) a_q = 1'b1;
            else if (r < 52) {a_n, a_d, a_q} = 3'($urandom_range(3, 7)) | 3'b011 & 3'($urandom_range(0, 7));
            a_nm = ($urandom_range(0, 15) == 0);
            a_dd = ($urandom_range(0, 2) == 0);
            a_ra = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 79) == 0);
            reset = rst;
            @(posedge clk);
            if (rst) begin
                m_credit = 0;
                m_mode   = 0;
                m_rej    = 0;
            end else begin
                model_step(a_n, a_d, a_q, a_nm, a_dd, a_ra);
            end
            #1;
            reset = 1'b0;
            exp = {8'(m_credit), (m_mode == 1), (m_mode == 2 && greedy(m_credit) == 5),
                   (m_mode == 2 && greedy(m_credit) == 10), (m_mode == 2 && greedy(m_credit) == 25),
                   (m_mode != 0), 1'(m_rej)};
            got = {a_credit, a_dis, a_rn, a_rd, a_rq, a_busy, a_rej};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: got credit=%0d dis/rn/rd/rq/busy/rej=%b, want credit=%0d %b",
                         i, got[13:6], got[5:0], exp[13:6], exp[5:0]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_quarter();
        test_exact_change();
        test_cancel();
        test_max_credit();
        test_rejects();
        test_reset_mid_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
